hack_cpu_mc: RTL and testbench

//  Multi-cycle, parametrised Hack CPU core with req/ack memory handshakes on separate

---
 rtl/hack_cpu_mc.sv | 190 +++++++++++++++++++
 tb/tb_hack_cpu_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : hack_cpu_mc
// Purpose  : Multi-cycle Hack A/C-instruction CPU with req/ack instruction and
//            data ports, optional self-loop halt and a retired-instruction count.
// Revision : 1.0
// ============================================================================
module hack_cpu_mc #(
  parameter int WIDTH   = 16,
  parameter int PC_W    = 15,
  parameter int DADDR_W = 15,
  parameter int HALT_EN = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [WIDTH-1:0]   imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [WIDTH-1:0]   dmem_wdata,
  input  logic               dmem_ack,
  input  logic [WIDTH-1:0]   dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [WIDTH-1:0]   a_reg,
  output logic [WIDTH-1:0]   d_reg,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MREAD  = 3'd2,
    S_EXEC   = 3'd3,
    S_MWRITE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   ir_q, ir_d;
  logic [WIDTH-1:0]   mbuf_q, mbuf_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               halted_q, halted_d;
  logic               imem_req_q, imem_req_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;

  logic [WIDTH-1:0]   alu_x0, alu_x1, alu_y, alu_y0, alu_y1, alu_o, alu_res;
  logic [WIDTH-1:0]   commit_val;
  logic               commit, zr, ng, jmp;
  logic [PC_W-1:0]    jmp_target;
  logic               unused_ir;

  assign unused_ir = ^ir_q[WIDTH-2:13];

  // x = D, y = A or M; control bits zx,nx,zy,ny,f,no live in ir[11:6]
  always_comb begin
    alu_y   = ir_q[12] ? mbuf_q : a_q;
    alu_x0  = ir_q[11] ? '0 : d_q;
    alu_x1  = ir_q[10] ? ~alu_x0 : alu_x0;
    alu_y0  = ir_q[9]  ? '0 : alu_y;
    alu_y1  = ir_q[8]  ? ~alu_y0 : alu_y0;
    alu_o   = ir_q[7]  ? (alu_x1 + alu_y1) : (alu_x1 & alu_y1);
    alu_res = ir_q[6]  ? ~alu_o : alu_o;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    d_d        = d_q;
    ir_d       = ir_q;
    mbuf_d     = mbuf_q;
    res_d      = res_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    commit     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_q[WIDTH-1]) begin
          a_d       = ir_q;
          pc_d      = pc_q + PC_W'(1);
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else begin
          state_d   = ir_q[12] ? S_MREAD : S_EXEC;
        end
      end
      S_MREAD: begin
        if (dmem_req_q && dmem_ack) begin
          mbuf_d  = dmem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = alu_res;
        if (ir_q[3]) state_d = S_MWRITE;
        else         commit  = 1'b1;
      end
      S_MWRITE: begin
        if (dmem_req_q && dmem_ack) commit = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // The store path commits from the latched result; the register-only path
    // commits straight from the ALU in the same cycle.
    commit_val = (state_q == S_MWRITE) ? res_q : alu_res;
    zr         = (commit_val == '0);
    ng         = commit_val[WIDTH-1];
    jmp        = (ng & ir_q[2]) | (zr & ir_q[1]) | (~ng & ~zr & ir_q[0]);
    jmp_target = a_q[PC_W-1:0];

    if (commit) begin
      if (jmp) begin
        pc_d = jmp_target;
        if ((HALT_EN != 0) && (jmp_target == pc_q)) halted_d = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
      if (ir_q[4]) d_d = commit_val;
      if (ir_q[5]) a_d = commit_val;
      retired_d = retired_q + CNT_W'(1);
      state_d   = S_FETCH;
    end

    imem_req_d = (state_d == S_FETCH) && !halted_d;
    dmem_req_d = (state_d == S_MREAD) || (state_d == S_MWRITE);
    dmem_we_d  = (state_d == S_MWRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      a_q        <= '0;
      d_q        <= '0;
      ir_q       <= '0;
      mbuf_q     <= '0;
      res_q      <= '0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      mbuf_q     <= mbuf_d;
      res_q      <= res_d;
      retired_q  <= retired_d;
      halted_q   <= halted_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  // Fetch request is primed for the first cycle after reset, so gate it here.
  assign imem_req   = imem_req_q & reset_n;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q & reset_n;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = a_q[DADDR_W-1:0];
  assign dmem_wdata = res_q;
  assign pc         = pc_q;
  assign a_reg      = a_q;
  assign d_reg      = d_q;
  assign halted     = halted_q;
  assign retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_cpu_mc
// Purpose  : Directed self-checking bench for hack_cpu_mc with wait-state memories.
// Revision : 1.0
// ============================================================================
module tb_hack_cpu_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];

  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [14:0] imem_addr, dmem_addr, pc;
  logic [15:0] imem_rdata, dmem_wdata, dmem_rdata, a_reg, d_reg;
  logic [31:0] retired;

  logic        imem_req_h0, imem_ack_h0, dmem_req_h0, dmem_we_h0, dmem_ack_h0, halted_h0;
  logic [14:0] imem_addr_h0, dmem_addr_h0, pc_h0;
  logic [15:0] imem_rdata_h0, dmem_wdata_h0, dmem_rdata_h0, a_reg_h0, d_reg_h0;
  logic [31:0] retired_h0;

  int          i_lat = 0, d_lat = 0, i_cnt = 0, d_cnt = 0;
  logic        stray_dack = 1'b0;
  int          wr_count = 0, unstable = 0;
  logic [14:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;
  logic        i_hold = 1'b0, d_hold = 1'b0;
  logic [14:0] i_addr_prev = '0, d_addr_prev = '0;
  logic [15:0] d_wdata_prev = '0;
  logic        d_we_prev = 1'b0;
  logic        d_model_ack;

  int checks = 0;
  int failures = 0;

  assign imem_rdata  = rom[imem_addr];
  assign dmem_rdata  = ram[dmem_addr];
  assign imem_ack    = imem_req && (i_cnt == i_lat);
  assign d_model_ack = dmem_req && (d_cnt == d_lat);
  assign dmem_ack    = d_model_ack || stray_dack;

  assign imem_rdata_h0 = rom[imem_addr_h0];
  assign imem_ack_h0   = imem_req_h0;
  assign dmem_ack_h0   = dmem_req_h0;
  assign dmem_rdata_h0 = 16'h0000;

  hack_cpu_mc #(.WIDTH(16), .PC_W(15), .DADDR_W(15), .HALT_EN(1), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .halted(halted), .retired(retired)
  );

  hack_cpu_mc #(.WIDTH(16), .PC_W(15), .DADDR_W(15), .HALT_EN(0), .CNT_W(32)) u_dut_h0 (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req_h0), .imem_addr(imem_addr_h0), .imem_ack(imem_ack_h0),
    .imem_rdata(imem_rdata_h0),
    .dmem_req(dmem_req_h0), .dmem_we(dmem_we_h0), .dmem_addr(dmem_addr_h0),
    .dmem_wdata(dmem_wdata_h0), .dmem_ack(dmem_ack_h0), .dmem_rdata(dmem_rdata_h0),
    .pc(pc_h0), .a_reg(a_reg_h0), .d_reg(d_reg_h0), .halted(halted_h0), .retired(retired_h0)
  );

  // Memory wait-state model, write log and request-stability monitor
  always @(posedge clk) begin
    if (imem_req && !imem_ack) i_cnt <= i_cnt + 1;
    else                       i_cnt <= 0;
    if (dmem_req && !d_model_ack) d_cnt <= d_cnt + 1;
    else                          d_cnt <= 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      wr_count   <= wr_count + 1;
      last_waddr <= dmem_addr;
      last_wdata <= dmem_wdata;
    end
    if (!reset_n) begin
      i_hold <= 1'b0;
      d_hold <= 1'b0;
    end else begin
      if (i_hold && (!imem_req || imem_addr != i_addr_prev)) unstable <= unstable + 1;
      if (d_hold && (!dmem_req || dmem_addr != d_addr_prev || dmem_we != d_we_prev ||
                     dmem_wdata != d_wdata_prev)) unstable <= unstable + 1;
      i_hold       <= imem_req && !imem_ack;
      d_hold       <= dmem_req && !dmem_ack;
      i_addr_prev  <= imem_addr;
      d_addr_prev  <= dmem_addr;
      d_we_prev    <= dmem_we;
      d_wdata_prev <= dmem_wdata;
    end
  end

  task automatic begin_prog();
    reset_n = 1'b0;
    stray_dack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  task automatic release_reset(input int il, input int dl);
    i_lat = il;
    d_lat = dl;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget, output int cyc);
    cyc = 0;
    while (retired != 32'(n) && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load_basic();
    rom[0] = 16'h0005; rom[1] = 16'hEC10;   // @5   D=A
    rom[2] = 16'h0007; rom[3] = 16'hE090;   // @7   D=D+A
    rom[4] = 16'h0000; rom[5] = 16'hE308;   // @0   M=D
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("FAIL rst_dmem got req=%b we=%b exp=0/0", dmem_req, dmem_we); end
    checks++; if (pc !== 15'd0 || retired !== 32'd0 || halted !== 1'b0) begin failures++; $display("FAIL rst_state got pc=%0h ret=%0d halt=%b exp=0/0/0", pc, retired, halted); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 15'd0) begin failures++; $display("FAIL rst_first_fetch got req=%b addr=%0h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_basic();
    int cyc;
    int wr0;
    begin_prog();
    load_basic();
    wr0 = wr_count;
    release_reset(0, 0);
    run_until(6, 200, cyc);
    checks++; if (retired !== 32'd6 || cyc !== 16) begin failures++; $display("FAIL basic_timing got ret=%0d cyc=%0d exp=6/16", retired, cyc); end
    checks++; if (a_reg !== 16'd0 || d_reg !== 16'd12 || pc !== 15'd6) begin failures++; $display("FAIL basic_regs got A=%0h D=%0h pc=%0h exp=0/c/6", a_reg, d_reg, pc); end
    checks++; if (wr_count - wr0 !== 1 || last_waddr !== 15'd0 || last_wdata !== 16'd12) begin failures++; $display("FAIL basic_write got n=%0d addr=%0h data=%0h exp=1/0/c", wr_count - wr0, last_waddr, last_wdata); end
  endtask

  task automatic test_wait_states();
    int cyc;
    int wr0;
    int us0;
    begin_prog();
    load_basic();
    wr0 = wr_count;
    us0 = unstable;
    release_reset(3, 3);
    run_until(6, 400, cyc);
    checks++; if (retired !== 32'd6 || cyc !== 37) begin failures++; $display("FAIL wait_timing got ret=%0d cyc=%0d exp=6/37", retired, cyc); end
    checks++; if (a_reg !== 16'd0 || d_reg !== 16'd12) begin failures++; $display("FAIL wait_regs got A=%0h D=%0h exp=0/c", a_reg, d_reg); end
    checks++; if (wr_count - wr0 !== 1 || last_waddr !== 15'd0 || last_wdata !== 16'd12) begin failures++; $display("FAIL wait_write got n=%0d addr=%0h data=%0h exp=1/0/c", wr_count - wr0, last_waddr, last_wdata); end
    checks++; if (unstable - us0 !== 0) begin failures++; $display("FAIL wait_stable got violations=%0d exp=0", unstable - us0); end
  endtask

  task automatic test_jump();
    int cyc;
    begin_prog();
    ram[3] = 16'hFFFC;
    rom[0] = 16'h0003; rom[1] = 16'hFC10;   // @3   D=M
    rom[2] = 16'h000A; rom[3] = 16'hE304;   // @10  D;JLT
    release_reset(0, 0);
    run_until(4, 100, cyc);
    checks++; if (pc !== 15'd10 || d_reg !== 16'hFFFC || cyc !== 11) begin failures++; $display("FAIL jlt_taken got pc=%0h D=%0h cyc=%0d exp=a/fffc/11", pc, d_reg, cyc); end
    begin_prog();
    ram[3] = 16'h0004;
    rom[0] = 16'h0003; rom[1] = 16'hFC10;
    rom[2] = 16'h000A; rom[3] = 16'hE304;
    release_reset(0, 0);
    run_until(4, 100, cyc);
    checks++; if (pc !== 15'd4 || d_reg !== 16'h0004) begin failures++; $display("FAIL jlt_fall got pc=%0h D=%0h exp=4/4", pc, d_reg); end
  endtask

  task automatic test_halt();
    int cyc;
    int req_seen;
    logic [31:0] r0;
    begin_prog();
    rom[0] = 16'h0003; rom[1] = 16'hEA87;   // @3   0;JMP  -> pc 3
    rom[3] = 16'hEA87;                      // 0;JMP with A=3 at pc 3
    release_reset(0, 0);
    cyc = 0;
    while (!halted && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (halted !== 1'b1 || cyc !== 8) begin failures++; $display("FAIL halt_set got halt=%b cyc=%0d exp=1/8", halted, cyc); end
    checks++; if (pc !== 15'd3 || retired !== 32'd3) begin failures++; $display("FAIL halt_state got pc=%0h ret=%0d exp=3/3", pc, retired); end
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) req_seen++;
    end
    checks++; if (req_seen !== 0 || retired !== 32'd3) begin failures++; $display("FAIL halt_parked got req_cycles=%0d ret=%0d exp=0/3", req_seen, retired); end
    checks++; if (halted_h0 !== 1'b0 || pc_h0 !== 15'd3) begin failures++; $display("FAIL nohalt_flag got halt=%b pc=%0h exp=0/3", halted_h0, pc_h0); end
    r0 = retired_h0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (retired_h0 - r0 !== 32'd10) begin failures++; $display("FAIL nohalt_loop got delta=%0d exp=10", retired_h0 - r0); end
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    int wr0;
    begin_prog();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'hE308;   // @5 D=A M=D
    release_reset(0, 20);
    cyc = 0;
    while (!(dmem_req && dmem_we) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'd5) begin failures++; $display("FAIL mid_reach got req=%b we=%b addr=%0h exp=1/1/5", dmem_req, dmem_we, dmem_addr); end
    repeat (2) @(negedge clk);
    wr0 = wr_count;
    reset_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL mid_drop got dreq=%b we=%b ireq=%b exp=0/0/0", dmem_req, dmem_we, imem_req); end
    checks++; if (pc !== 15'd0 || a_reg !== 16'd0 || d_reg !== 16'd0 || retired !== 32'd0) begin failures++; $display("FAIL mid_regs got pc=%0h A=%0h D=%0h ret=%0d exp=0/0/0/0", pc, a_reg, d_reg, retired); end
    stray_dack = 1'b1;
    i_lat = 4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (retired !== 32'd0 || pc !== 15'd0 || dmem_req !== 1'b0 || wr_count !== wr0) begin failures++; $display("FAIL mid_stray got ret=%0d pc=%0h dreq=%b writes=%0d exp=0/0/0/%0d", retired, pc, dmem_req, wr_count, wr0); end
    stray_dack = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    int wr0;
    begin_prog();
    ram[15'h7FFF] = 16'hFFFF;
    rom[0] = 16'h7FFE; rom[1] = 16'hEA87;                 // @0x7FFE 0;JMP
    rom[15'h7FFE] = 16'h7FFF; rom[15'h7FFF] = 16'hFDE8;   // @0x7FFF AM=M+1
    wr0 = wr_count;
    release_reset(0, 0);
    run_until(4, 100, cyc);
    checks++; if (pc !== 15'd0 || a_reg !== 16'd0 || cyc !== 12) begin failures++; $display("FAIL wrap_pc got pc=%0h A=%0h cyc=%0d exp=0/0/12", pc, a_reg, cyc); end
    checks++; if (wr_count - wr0 !== 1 || last_waddr !== 15'h7FFF || last_wdata !== 16'h0000) begin failures++; $display("FAIL wrap_write got n=%0d addr=%0h data=%0h exp=1/7fff/0", wr_count - wr0, last_waddr, last_wdata); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL wrap_halt got halt=%b exp=0", halted); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
    test_reset();
    test_basic();
    test_wait_states();
    test_jump();
    test_halt();
    test_reset_mid_write();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
